// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the two-port arbiter: request/ready handshake plus address and data.
// The arbiter drives it through the master modport. The memory model drives it through the slave modport.
interface mem_arbiter_if #(
  parameter int W = 32
);
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_adr;
  logic [W-1:0] mem_wd;
  logic [W-1:0] mem_rd;
  logic         mem_ready;

  modport master (
    output mem_req, mem_we, mem_adr, mem_wd,
    input  mem_rd, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_adr, mem_wd,
    output mem_rd, mem_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory between the core (port 0) and a loader/DMA (port 1).
// A watchdog aborts any access whose mem_ready never arrives.
module mem_arbiter #(
  parameter int W       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [W-1:0]  adr0,
  input  logic [W-1:0]  adr1,
  input  logic [W-1:0]  wd0,
  input  logic [W-1:0]  wd1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic [W-1:0]  rd,
  mem_arbiter_if.master mem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic          gnt;
  logic          last;
  logic          we_q;
  logic [W-1:0]  adr_q;
  logic [W-1:0]  wd_q;
  logic [W-1:0]  rd_q;
  logic          err_q;
  logic [CW-1:0] cnt;
  logic          pick;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~last;
  end

  // The latched request registers double as the memory-side outputs, so they are cleared when BUSY ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
      we_q  <= 1'b0;
      adr_q <= '0;
      wd_q  <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
      done0 <= 1'b0;
      done1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state <= BUSY;
            gnt   <= pick;
            last  <= pick;
            we_q  <= pick ? we1 : we0;
            adr_q <= pick ? adr1 : adr0;
            wd_q  <= pick ? wd1 : wd0;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (mem.mem_ready || cnt == CW'(TIMEOUT - 1)) begin
            state <= DONE;
            done0 <= ~gnt;
            done1 <= gnt;
            err_q <= ~mem.mem_ready;
            rd_q  <= (mem.mem_ready && !we_q) ? mem.mem_rd : '0;
            we_q  <= 1'b0;
            adr_q <= '0;
            wd_q  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done0 <= 1'b0;
          done1 <= 1'b0;
          rd_q  <= '0;
          err_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem.mem_req = (state == BUSY);
  assign mem.mem_we  = we_q;
  assign mem.mem_adr = adr_q;
  assign mem.mem_wd  = wd_q;
  assign rd          = rd_q;
  assign err0        = err_q & ~gnt;
  assign err1        = err_q & gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic.
// Expectations come from a transaction-level model of the arbitration and timeout rules.
module tb_mem_arbiter;

  localparam int W       = 32;
  localparam int TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1, we0, we1;
  logic [W-1:0] adr0, adr1, wd0, wd1;
  logic         done0, done1, err0, err1;
  logic [W-1:0] rd;

  int tests  = 0;
  int failed = 0;
  bit last_gnt = 1'b1;

  mem_arbiter_if #(.W(W)) bus ();

  mem_arbiter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .we0   (we0),
    .we1   (we1),
    .adr0  (adr0),
    .adr1  (adr1),
    .wd0   (wd0),
    .wd1   (wd1),
    .done0 (done0),
    .done1 (done1),
    .err0  (err0),
    .err1  (err1),
    .rd    (rd),
    .mem   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    check_output({tag, "_mem_we"},  32'(bus.mem_we),  32'd0);
    check_output({tag, "_mem_adr"}, bus.mem_adr,      32'd0);
    check_output({tag, "_mem_wd"},  bus.mem_wd,       32'd0);
    check_output({tag, "_done0"},   32'(done0),       32'd0);
    check_output({tag, "_done1"},   32'(done1),       32'd0);
    check_output({tag, "_err0"},    32'(err0),        32'd0);
    check_output({tag, "_err1"},    32'(err1),        32'd0);
    check_output({tag, "_rd"},      rd,               32'd0);
  endtask

  task automatic apply_stimulus(input bit port, input logic r, input logic w, input logic [W-1:0] a, input logic [W-1:0] d);
    if (port) begin
      req1 = r; we1 = w; adr1 = a; wd1 = d;
    end else begin
      req0 = r; we0 = w; adr0 = a; wd0 = d;
    end
  endtask

  // Runs one access from the current IDLE cycle. latency > TIMEOUT means the memory never answers.
  task automatic serve(input string tag, input int latency, input logic [W-1:0] data);
    bit           w;
    logic         exp_we;
    logic [W-1:0] exp_adr, exp_wd, exp_rd;
    bit           exp_err;
    int           busy_len;
    w        = (req0 && req1) ? !last_gnt : req1;
    exp_we   = w ? we1 : we0;
    exp_adr  = w ? adr1 : adr0;
    exp_wd   = w ? wd1 : wd0;
    exp_err  = (latency > TIMEOUT);
    busy_len = exp_err ? TIMEOUT : latency;
    exp_rd   = (exp_err || exp_we) ? '0 : data;
    for (int k = 0; k < busy_len; k++) begin
      @(negedge clk);
      check_output({tag, "_mem_req"}, 32'(bus.mem_req), 32'd1);
      check_output({tag, "_mem_we"},  32'(bus.mem_we),  32'(exp_we));
      check_output({tag, "_mem_adr"}, bus.mem_adr,      exp_adr);
      check_output({tag, "_mem_wd"},  bus.mem_wd,       exp_wd);
      check_output({tag, "_busy_done"}, 32'(done0 | done1), 32'd0);
      apply_stimulus(w, 1'b1, 1'($urandom), $urandom, $urandom);
      bus.mem_ready = (k == latency - 1);
      bus.mem_rd    = (k == latency - 1) ? data : $urandom;
    end
    @(negedge clk);
    bus.mem_ready = 1'($urandom);
    bus.mem_rd    = $urandom;
    check_output({tag, "_done_w"},  32'(w ? done1 : done0), 32'd1);
    check_output({tag, "_done_o"},  32'(w ? done0 : done1), 32'd0);
    check_output({tag, "_err_w"},   32'(w ? err1 : err0),   32'(exp_err));
    check_output({tag, "_err_o"},   32'(w ? err0 : err1),   32'd0);
    check_output({tag, "_rd"},      rd,                     exp_rd);
    check_output({tag, "_done_mem_req"}, 32'(bus.mem_req),  32'd0);
    if (w) req1 = 1'b0; else req0 = 1'b0;
    last_gnt = w;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    check_output({tag, "_idle_mem_req"}, 32'(bus.mem_req), 32'd0);
    check_output({tag, "_idle_done"},    32'(done0 | done1), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
    bus.mem_ready = 1'b0;
    bus.mem_rd    = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Contention out of reset: port 0 first, then strict alternation.
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h200, 32'hA5A5_0001);
    for (int i = 0; i < 4; i++) begin
      serve("tie", 1 + (i % 2), 32'hC0DE_0000 + 32'(i));
      apply_stimulus(last_gnt, 1'b1, 1'b0, 32'h300 + 32'(i * 4), 32'h0);
    end
    serve("tie_last", 1, 32'h1111_2222);
    serve("tie_drain", 2, 32'h3333_4444);

    // Single read, port 0, memory ready in the first BUSY cycle.
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    serve("read0", 1, 32'hDEAD_BEEF);

    // Write, port 1, three-cycle memory.
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    serve("write1", 3, 32'hFFFF_FFFF);

    // Watchdog abort followed by late ready pulses that must be ignored.
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h44, 32'h0);
    serve("timeout", TIMEOUT + 1, 32'hBAD0_BAD0);
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'b1;
      bus.mem_rd    = 32'hFACE_FACE;
      @(negedge clk);
      check_output("late_ready_done", 32'(done0 | done1), 32'd0);
      check_output("late_ready_req",  32'(bus.mem_req),   32'd0);
    end
    bus.mem_ready = 1'b0;

    // Reset in the middle of a port-1 read drops the access silently.
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
    @(negedge clk);
    check_output("rst_busy_req", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("rst_async");
    req1 = 1'b0;
    last_gnt = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("rst_no_done1", 32'(done1), 32'd0);
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h500, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h600, 32'h0);
    serve("rst_tie", 1, 32'h0BAD_F00D);
    serve("rst_tie2", 1, 32'h600D_F00D);

    // Random traffic; a port whose request is still pending keeps its inputs.
    for (int i = 0; i < 40; i++) begin
      if (!req0 && $urandom_range(0, 1) == 1)
        apply_stimulus(1'b0, 1'b1, 1'($urandom), $urandom, $urandom);
      if (!req1 && $urandom_range(0, 1) == 1)
        apply_stimulus(1'b1, 1'b1, 1'($urandom), $urandom, $urandom);
      if (!req0 && !req1)
        apply_stimulus(1'($urandom), 1'b1, 1'($urandom), $urandom, $urandom);
      serve("rand", $urandom_range(1, TIMEOUT + 2), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
